seg7_scan_ctrl: RTL
===================

Name: seg7_scan_ctrl

Overview:
- Multi-digit hex seven-segment display controller, the parametrised successor to the single-digit combinational hex decoder.
- Holds a DIGITS-wide display register loaded by strobe, with per-digit enable, decimal-point and leading-zero blanking control.
- Drives two outputs: a static per-digit segment bus for boards with one segment bus per digit, and a time-multiplexed scan output (shared segments plus one-hot anode select) for boards with a shared segment bus.

Parameters:
DIGITS, 8, number of digits; legal 1..8
SCAN_DIV, 1000, clk cycles each digit is held on the scan output; legal >= 2

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
load  in  1  capture value/en_mask/dp_mask/lz_blank into display registers
value  in  4*DIGITS  hex nibble per digit; digit i = value[4i+3:4i], digit 0 rightmost
en_mask  in  DIGITS  1 = digit i shown, 0 = digit i fully dark (dp included)
dp_mask  in  DIGITS  1 = decimal point of digit i lit
lz_blank  in  1  1 = suppress leading zeros
seg_all  out  8*DIGITS  static glyphs; digit i = seg_all[8i+7:8i]
seg  out  8  multiplexed glyph of currently scanned digit
an  out  DIGITS  active-low one-hot digit select for seg
frame  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is synchronous and active-low: sampled on the clk rising edge while rst_n=0.
- Glyph format: 8 bits, active-low (0 = segment lit).
  - bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp.
  - Hex glyphs with dp off: 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09, A=11, b=C1, C=63, d=85, E=61, F=71.
  - dp lit clears bit0.
- Reset: display registers all 0, en_mask_r=0, dp_mask_r=0, lz_r=0, prescaler=0, idx=0.
  - Outputs during and after reset: seg_all=all FF, seg=FF, an=all 1s, frame=0.
- Load:
  - On a rising edge with load=1, the inputs are registered.
  - seg_all reflects the new data on the following edge (2 edges after load sampled).
  - load held high re-captures every cycle; the last captured value wins.
  - Inputs are ignored when load=0.
- Per-digit glyph g(i), computed from the registered state:
  - en_mask_r[i]=0: FF.
  - Else if blanked(i): FF with bit0 cleared when dp_mask_r[i]=1.
  - Else: hex glyph of nibble i, with bit0 cleared when dp_mask_r[i]=1.
  - blanked(i) = lz_r AND i>0 AND nibbles i..DIGITS-1 all zero (disabled digits still count by nibble value).
  - Digit 0 is never leading-zero blanked.
- Static output: seg_all registered, seg_all[8i+7:8i] <= g(i) every cycle.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - On the cycle the prescaler equals SCAN_DIV-1:
    - idx <= (idx==DIGITS-1) ? 0 : idx+1.
    - an <= all 1s (one-cycle anti-ghost gap).
    - frame <= 1 if idx==DIGITS-1.
  - On the cycle the prescaler equals 0: an <= ~(1<<idx), seg <= g(idx).
  - Other cycles: seg <= g(idx), so a load becomes visible mid-slot; an holds.
  - The first digit-0 slot starts one cycle after reset release. Each digit is selected for SCAN_DIV-1 cycles, then a 1-cycle gap; the scan period is DIGITS*SCAN_DIV cycles.
- DIGITS=1: idx stays 0, and frame pulses every SCAN_DIV cycles.
- Reset mid-scan: all state returns to reset values on the next edge with no partial gap or pulse.
- Simultaneous load and scan wrap are independent; the wrap is unaffected.
- seg_all has no multiplex gap.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with load=1 and value=12345678 -> seg_all all FF, seg=FF, an=FF, frame=0 throughout; the load is ignored.
- Static load, DIGITS=8: load 1 cycle with value=0123ABCD, en_mask=FF, dp_mask=00, lz_blank=0 -> 2 edges later seg_all = 03,9F,25,0D,11,C1,63,85 (digit7..digit0).
- Leading-zero and dp: value=0000_0F05, en_mask=FF, dp_mask=02, lz_blank=1 ->
  - digits 7..3 = FF.
  - digit 2 = 71, digit 1 = 02 (0 glyph with dp), digit 0 = 49.
  - value=0 with lz_blank=1 -> only digit 0 shows 03.
- Enable mask: en_mask=0F, dp_mask=F0 -> digits 7..4 = FF despite dp_mask; digits 3..0 show glyphs.
- Scan timing, SCAN_DIV=4, DIGITS=4:
  - an sequence from reset release: E (3 cycles), F (1 cycle), D (3), F, B (3), F, 7 (3), F, E...
  - frame high exactly on the gap cycle after an=7.
  - seg matches the seg_all slice of the selected digit.
- Reset mid-frame: deassert then reassert rst_n while an=B -> next edge an=F, seg=FF; after release the scan restarts at digit 0 with a full 3-cycle slot.

Source files
------------

// File: rtl/seg7_scan_ctrl_if.sv
// Bus bundle for the seven-segment scan controller: display load inputs
// (driven by the master) and the static/multiplexed glyph outputs.
interface seg7_scan_ctrl_if #(
  parameter int DIGITS = 8
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     en_mask;
  logic [DIGITS-1:0]     dp_mask;
  logic                  lz_blank;
  logic [8*DIGITS-1:0]   seg_all;
  logic [7:0]            seg;
  logic [DIGITS-1:0]     an;
  logic                  frame;

  modport master (
    output load, value, en_mask, dp_mask, lz_blank,
    input  seg_all, seg, an, frame
  );

  modport slave (
    input  load, value, en_mask, dp_mask, lz_blank,
    output seg_all, seg, an, frame
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multi-digit hex seven-segment controller. Glyphs are active-low
// {a,b,c,d,e,f,g,dp}. Produces a registered static per-digit segment bus and
// a time-multiplexed scan (shared segments + active-low one-hot anodes) with
// a one-cycle blank gap between digit slots.
module seg7_scan_ctrl #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 1000
) (
  input  logic            clk,
  input  logic            rst_n,
  seg7_scan_ctrl_if.slave bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PSC_W = $clog2(SCAN_DIV);
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [4*DIGITS-1:0] r_value;
  logic [DIGITS-1:0]   r_en;
  logic [DIGITS-1:0]   r_dp;
  logic                r_lz;
  logic [PSC_W-1:0]    r_psc;
  logic [IDX_W-1:0]    r_idx;
  logic [8*DIGITS-1:0] r_seg_all;
  logic [7:0]          r_seg;
  logic [DIGITS-1:0]   r_an;
  logic                r_frame;
  logic [8*DIGITS-1:0] w_glyph;

  function automatic logic [7:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 8'h03;
      4'h1: hex_glyph = 8'h9F;
      4'h2: hex_glyph = 8'h25;
      4'h3: hex_glyph = 8'h0D;
      4'h4: hex_glyph = 8'h99;
      4'h5: hex_glyph = 8'h49;
      4'h6: hex_glyph = 8'h41;
      4'h7: hex_glyph = 8'h1F;
      4'h8: hex_glyph = 8'h01;
      4'h9: hex_glyph = 8'h09;
      4'hA: hex_glyph = 8'h11;
      4'hB: hex_glyph = 8'hC1;
      4'hC: hex_glyph = 8'h63;
      4'hD: hex_glyph = 8'h85;
      4'hE: hex_glyph = 8'h61;
      default: hex_glyph = 8'h71;
    endcase
  endfunction

  // Capture the display registers on load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_value <= '0;
      r_en    <= '0;
      r_dp    <= '0;
      r_lz    <= 1'b0;
    end else if (bus.load) begin
      r_value <= bus.value;
      r_en    <= bus.en_mask;
      r_dp    <= bus.dp_mask;
      r_lz    <= bus.lz_blank;
    end
  end

  // Per-digit glyphs; walks from the top digit down so w_run tracks whether
  // every nibble from the top through the current digit is zero.
  always_comb begin : glyph_gen
    logic        w_run;
    logic [3:0]  w_nib;
    logic [7:0]  w_g;
    int unsigned i;
    w_glyph = '1;
    w_run   = 1'b1;
    w_nib   = '0;
    w_g     = '1;
    i       = 0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      i     = DIGITS - 1 - k;
      w_nib = r_value[4*i +: 4];
      w_run = w_run & (w_nib == 4'h0);
      w_g   = (r_lz && (i != 0) && w_run) ? 8'hFF : hex_glyph(w_nib);
      if (r_dp[i]) w_g[0] = 1'b0;
      if (!r_en[i]) w_g = '1;
      w_glyph[8*i +: 8] = w_g;
    end
  end

  // Static output: every digit registered each cycle, no multiplex gap.
  always_ff @(posedge clk) begin
    if (!rst_n) r_seg_all <= '1;
    else        r_seg_all <= w_glyph;
  end

  // Scan engine: prescaler slots, anode select with anti-ghost gap, frame pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_psc   <= '0;
      r_idx   <= '0;
      r_an    <= '1;
      r_seg   <= '1;
      r_frame <= 1'b0;
    end else begin
      r_frame <= 1'b0;
      r_seg   <= w_glyph[8*r_idx +: 8];
      if (r_psc == PSC_LAST) begin
        r_psc   <= '0;
        r_an    <= '1;
        r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        r_frame <= (r_idx == IDX_LAST);
      end else begin
        r_psc <= r_psc + 1'b1;
        if (r_psc == '0) r_an <= ~(DIGITS'(1) << r_idx);
      end
    end
  end

  assign bus.seg_all = r_seg_all;
  assign bus.seg     = r_seg;
  assign bus.an      = r_an;
  assign bus.frame   = r_frame;

endmodule
